gray_counter: RTL

- Parameterised up/down counter that keeps an internal binary count and drives a registered, glitch-free Gray-code output.
- Produces the Gray pointers that the existing Gray-to-binary decoder consumes across clock-domain boundaries, for example FIFO read/write pointers.
- Both the binary and Gray views are registered and change on the same clock edge.

---
 rtl/gray_pkg.sv | 23 ++
 rtl/bin_to_gray.sv | 13 +
 rtl/gray_counter.sv | 66 ++++++
 3 files changed

// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter and anything that consumes its pointers.
package gray_pkg;

  localparam int unsigned DefaultWidth = 4;
  // Widest value the helper functions handle; narrower callers zero-extend.
  localparam int unsigned MaxWidth     = 32;

  // Binary to reflected Gray code. Zero-extension keeps it correct for any width <= MaxWidth.
  function automatic logic [MaxWidth-1:0] bin2gray(input logic [MaxWidth-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray back to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [MaxWidth-1:0] gray2bin(input logic [MaxWidth-1:0] g);
    logic [MaxWidth-1:0] b;
    b[MaxWidth-1] = g[MaxWidth-1];
    for (int i = MaxWidth - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-to-Gray converter, width-parameterised.
module bin_to_gray
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_counter.sv
// Up/down counter holding a binary count and a registered, glitch-free Gray copy of it.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray,
  output logic             wrap,
  output logic             at_term
);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;

  // Next-state selection: load beats enable, enable beats hold.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up_dn) begin
        bin_d  = bin_q + WIDTH'(1);
        wrap_d = &bin_q;
      end else begin
        bin_d  = bin_q - WIDTH'(1);
        wrap_d = ~|bin_q;
      end
    end
  end

  // Gray is encoded from the next binary value so both registers update on the same edge.
  bin_to_gray #(
    .WIDTH(WIDTH)
  ) u_bin_to_gray (
    .bin_i (bin_d),
    .gray_o(gray_d)
  );

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin     = bin_q;
  assign gray    = gray_q;
  assign wrap    = wrap_q;
  assign at_term = up_dn ? (&bin_q) : (~|bin_q);

endmodule
